// File: rtl/locked_irq_pkg.sv
// Shared types, constants and helpers for the locked priority interrupt controller.
package locked_irq_pkg;

    typedef enum logic [1:0] {
        LOCKED = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    localparam logic [3:0]  LUT_AND = 4'b1000;
    localparam int unsigned LUT_W   = 4;
    localparam int unsigned XOR_LSB = 0;

    // The LUT field sits directly above the NCH XOR key bits.
    function automatic int unsigned lut_lsb(input int unsigned nch);
        return nch;
    endfunction

    function automatic int unsigned prio_enc(input logic [31:0] vec);
        int unsigned idx;
        logic        found;
        idx   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (vec[i] && !found) begin
                idx   = i;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/locked_prio_irq_ctrl_key_shift_loader.sv
// Serial key loader: LOCKED/LOAD/ACTIVE FSM, bit counter and key register.
// Optional even-parity check on the final key bit under KEY_PARITY_EN.
module key_shift_loader
    import locked_irq_pkg::*;
#(
    parameter int unsigned KEY_W = 13
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             key_load_i,
    input  logic             key_bit_i,
    input  logic             key_bit_valid_i,
    output logic [KEY_W-1:0] key_o,
    output logic             key_loaded_o
`ifdef KEY_PARITY_EN
    ,
    output logic             key_err_o
`endif
);

    localparam int unsigned CW = $clog2(KEY_W + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [KEY_W-1:0] key_q, key_d;
`ifdef KEY_PARITY_EN
    logic             err_q, err_d;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= LOCKED;
            cnt_q   <= '0;
            key_q   <= '0;
`ifdef KEY_PARITY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
`ifdef KEY_PARITY_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
`ifdef KEY_PARITY_EN
        err_d   = 1'b0;
`endif
        // key_load restarts from any state and masks a same-cycle key bit.
        if (key_load_i) begin
            state_d = LOAD;
            cnt_d   = '0;
            key_d   = '0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (key_bit_valid_i) begin
                        key_d[cnt_q] = key_bit_i;
                        cnt_d        = cnt_q + 1'b1;
                        if (cnt_q == CW'(KEY_W - 1)) begin
`ifdef KEY_PARITY_EN
                            if (^key_d) begin
                                state_d = LOCKED;
                                key_d   = '0;
                                err_d   = 1'b1;
                            end else begin
                                state_d = ACTIVE;
                            end
`else
                            state_d = ACTIVE;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign key_o        = key_q;
    assign key_loaded_o = (state_q == ACTIVE);
`ifdef KEY_PARITY_EN
    assign key_err_o    = err_q;
`endif

endmodule

// File: rtl/locked_prio_irq_ctrl.sv
// Registered fixed-priority interrupt controller with XOR- and LUT-locked requests.
// Define KEY_PARITY_EN to append a parity bit to the key and expose key_err.
module locked_prio_irq_ctrl
    import locked_irq_pkg::*;
#(
    parameter int unsigned     NCH    = 9,
    parameter logic [NCH-1:0]  KPOL   = 9'h0A5,
    parameter int unsigned     LUT_CH = 6,
`ifdef KEY_PARITY_EN
    parameter int unsigned     KEY_W  = NCH + 5
`else
    parameter int unsigned     KEY_W  = NCH + 4
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         req,
    input  logic [NCH-1:0]         en,
    input  logic                   key_load,
    input  logic                   key_bit,
    input  logic                   key_bit_valid,
    output logic                   key_loaded,
    output logic                   irq_valid,
    output logic [$clog2(NCH)-1:0] irq_id,
    input  logic                   irq_ready
`ifdef KEY_PARITY_EN
    ,
    output logic                   key_err
`endif
);

    localparam int unsigned IDW     = $clog2(NCH);
    localparam int unsigned LUT_LSB = lut_lsb(NCH);

    logic [KEY_W-1:0] key_w;
    logic             key_loaded_w;
    logic [NCH-1:0]   req_q;
    logic [NCH-1:0]   xr;
    logic [NCH-1:0]   req_eff;
    logic [LUT_W-1:0] lut_p;
    logic             irq_valid_q, irq_valid_d;
    logic [IDW-1:0]   irq_id_q, irq_id_d;

    key_shift_loader #(
        .KEY_W (KEY_W)
    ) u_loader (
        .clk_i           (clk),
        .rst_i           (rst),
        .key_load_i      (key_load),
        .key_bit_i       (key_bit),
        .key_bit_valid_i (key_bit_valid),
        .key_o           (key_w),
        .key_loaded_o    (key_loaded_w)
`ifdef KEY_PARITY_EN
        ,
        .key_err_o       (key_err)
`endif
    );

    always_comb begin
        lut_p           = key_w[LUT_LSB +: LUT_W];
        xr              = req_q ^ key_w[XOR_LSB +: NCH] ^ KPOL;
        req_eff         = xr & en;
        // The LUT replaces the AND gate on this channel; LUT_AND restores it.
        req_eff[LUT_CH] = lut_p[{xr[LUT_CH], en[LUT_CH]}];
    end

    always_comb begin
        irq_valid_d = irq_valid_q;
        irq_id_d    = irq_id_q;
        if (key_load) begin
            irq_valid_d = 1'b0;
        end else if (!irq_valid_q || irq_ready) begin
            irq_valid_d = key_loaded_w & (|req_eff);
            if (irq_valid_d) begin
                irq_id_d = IDW'(prio_enc(32'(req_eff)));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q       <= '0;
            irq_valid_q <= 1'b0;
            irq_id_q    <= '0;
        end else begin
            req_q       <= req;
            irq_valid_q <= irq_valid_d;
            irq_id_q    <= irq_id_d;
        end
    end

    assign key_loaded = key_loaded_w;
    assign irq_valid  = irq_valid_q;
    assign irq_id     = irq_id_q;

endmodule

// File: tb/tb_locked_prio_irq_ctrl.sv
// Scoreboard bench for locked_prio_irq_ctrl; accepted grant ids are checked by a monitor.
// Also covers the KEY_PARITY_EN build when that macro is defined.
module tb_locked_prio_irq_ctrl;

    localparam int unsigned NCH = 9;
`ifdef KEY_PARITY_EN
    localparam int unsigned KW = 14;
`else
    localparam int unsigned KW = 13;
`endif
    localparam logic [12:0] KEY_OK      = 13'h10A5;
    localparam logic [12:0] KEY_BAD_X0  = 13'h10A4;
    localparam logic [12:0] KEY_BAD_LUT = 13'h00A5;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] req;
    logic [NCH-1:0] en;
    logic           key_load;
    logic           key_bit;
    logic           key_bit_valid;
    logic           key_loaded;
    logic           irq_valid;
    logic [3:0]     irq_id;
    logic           irq_ready;
`ifdef KEY_PARITY_EN
    logic           key_err;
`endif

    int tests = 0;
    int fails = 0;
    int exp_q[$];

    locked_prio_irq_ctrl #(
        .NCH    (NCH),
        .KPOL   (9'h0A5),
        .LUT_CH (6)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .en            (en),
        .key_load      (key_load),
        .key_bit       (key_bit),
        .key_bit_valid (key_bit_valid),
        .key_loaded    (key_loaded),
        .irq_valid     (irq_valid),
        .irq_id        (irq_id),
        .irq_ready     (irq_ready)
`ifdef KEY_PARITY_EN
        ,
        .key_err       (key_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted grant must match the next queued expectation.
    always @(negedge clk) begin
        int e;
        if (!rst && irq_valid && irq_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_grant: got id %0d, expected no grant", irq_id);
            end else begin
                e = exp_q.pop_front();
                check("grant_id", irq_id, e);
            end
        end
    end

    task automatic accept();
        int unsigned n;
        n = 0;
        while (!irq_valid && n < 20) begin
            tick();
            n++;
        end
        if (!irq_valid) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: irq_valid %0b, expected 1", irq_valid);
        end else begin
            irq_ready = 1'b1;
            tick();
            irq_ready = 1'b0;
        end
    endtask

    task automatic load_key(input logic [12:0] k, input logic rdy, input logic bad_par);
        logic [KW-1:0] full;
        full       = '0;
        full[12:0] = k;
`ifdef KEY_PARITY_EN
        full[13]   = (^k) ^ bad_par;
`endif
        key_load = 1'b1;
        key_bit_valid = 1'b1;
        key_bit = 1'b1;
        tick();
        key_load = 1'b0;
        key_bit_valid = 1'b0;
        check("kl_clear_loaded", key_loaded, 0);
        check("kl_clear_valid", irq_valid, 0);
        irq_ready = rdy;
        for (int unsigned i = 0; i < KW; i++) begin
            if (i == KW - 1) check("loaded_early", key_loaded, 0);
            key_bit       = full[i];
            key_bit_valid = 1'b1;
            tick();
        end
        key_bit_valid = 1'b0;
        key_bit       = 1'b0;
        check("key_loaded", key_loaded, {31'b0, !bad_par});
`ifdef KEY_PARITY_EN
        check("key_err", key_err, {31'b0, bad_par});
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = '0; en = '0; key_load = 1'b0;
        key_bit = 1'b0; key_bit_valid = 1'b0; irq_ready = 1'b0;
        tick();
        tick();
        check("rst_loaded", key_loaded, 0);
        check("rst_valid", irq_valid, 0);
        check("rst_id", irq_id, 0);
        rst = 1'b0;

        load_key(KEY_OK, 1'b0, 1'b0);

        en  = '1;
        req = 9'b001001000;
        tick();
        check("lat_t1_valid", irq_valid, 0);
        tick();
        check("lat_t2_valid", irq_valid, 1);
        check("lat_t2_id", irq_id, 3);
        exp_q.push_back(3); accept();
        exp_q.push_back(3); accept();

        req = 9'b001000000;
        tick();
        exp_q.push_back(3); accept();
        check("drop3_valid", irq_valid, 1);
        check("drop3_id", irq_id, 6);

        req = 9'b001000001;
        tick(); tick(); tick();
        check("hold_valid", irq_valid, 1);
        check("hold_id", irq_id, 6);
        exp_q.push_back(6); accept();
        exp_q.push_back(0); accept();

        // Reload mid-grant with ready high: no grant may appear before ACTIVE.
        load_key(KEY_OK, 1'b1, 1'b0);
        irq_ready = 1'b0;
        check("reload_first_valid", irq_valid, 0);
        tick();
        check("reload_valid", irq_valid, 1);
        check("reload_id", irq_id, 0);
        exp_q.push_back(0); accept();

        req = '0;
        en  = 9'b000000001;
        load_key(KEY_BAD_X0, 1'b0, 1'b0);
        check("wrongkey_first_valid", irq_valid, 0);
        tick();
        check("wrongkey_valid", irq_valid, 1);
        check("wrongkey_id", irq_id, 0);
        exp_q.push_back(0); accept();

        en  = '1;
        req = 9'b001000000;
        load_key(KEY_BAD_LUT, 1'b0, 1'b0);
        tick(); tick(); tick();
        check("lut_zero_valid", irq_valid, 0);

        load_key(KEY_OK, 1'b0, 1'b0);
        tick();
        check("pre_rst_valid", irq_valid, 1);
        check("pre_rst_id", irq_id, 6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_hs_valid", irq_valid, 0);
        check("rst_hs_id", irq_id, 0);
        check("rst_hs_loaded", key_loaded, 0);

        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            key_bit = KEY_OK[i]; key_bit_valid = 1'b1; tick();
        end
        key_bit_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int unsigned i = 5; i < KW; i++) begin
            key_bit = (i < 13) ? KEY_OK[i] : 1'b1; key_bit_valid = 1'b1; tick();
        end
        key_bit_valid = 1'b0;
        tick(); tick();
        check("rst_load_loaded", key_loaded, 0);
        check("rst_load_valid", irq_valid, 0);

`ifdef KEY_PARITY_EN
        load_key(KEY_OK, 1'b0, 1'b1);
        tick();
        check("par_err_pulse_end", key_err, 0);
        check("par_err_loaded", key_loaded, 0);
        check("par_err_valid", irq_valid, 0);
        load_key(KEY_OK, 1'b0, 1'b0);
        tick();
        check("par_ok_valid", irq_valid, 1);
        check("par_ok_id", irq_id, 6);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/locked_prio_irq_ctrl.md
Name: locked_prio_irq_ctrl

Overview:
- Parametrised, registered successor to the combinational locked priority-interrupt benchmarks.
- N-channel fixed-priority interrupt controller with XOR key gates on request lines and a 4-entry key-programmed LUT on one channel's qualify node.
- Keys arrive over a serial key-load interface; the grant is delivered by a valid/ready handshake.
- Serves as a sequential target for the deobfuscation flow.

Parameters:
- NCH, 9, number of interrupt channels (2..32).
- KPOL, 9'h0A5, NCH-bit XOR polarity; the correct XOR key equals KPOL.
- LUT_CH, 6, channel whose qualify node is LUT-locked (0..NCH-1).
- KEY_W, NCH+4, total key length: bits [NCH-1:0] are XOR keys, [NCH+3:NCH] are LUT keys p[3:0].

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- req, in, NCH: level-sensitive interrupt requests.
- en, in, NCH: per-channel enable.
- key_load, in, 1: pulse; start a new key load.
- key_bit, in, 1: serial key data, LSB first.
- key_bit_valid, in, 1: key_bit qualifier.
- key_loaded, out, 1: key register full and in use.
- irq_valid, out, 1: a grant is pending.
- irq_id, out, $clog2(NCH): granted channel index.
- irq_ready, in, 1: consumer accepts the grant.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- Reset: FSM=LOCKED, key register=0, bit counter=0, req_q=0, key_loaded=0, irq_valid=0, irq_id=0.
- FSM states:
  - LOCKED: outputs idle. key_load -> LOAD.
  - LOAD: each key_bit_valid shifts key_bit into key[cnt], then cnt++. When cnt reaches KEY_W-1 with valid -> ACTIVE and key_loaded=1 next cycle.
  - ACTIVE: arbitration runs. key_load -> LOAD.
- key_load in any state: clear key register and cnt; key_loaded=0 and irq_valid=0 on the next cycle. A key_bit_valid in the same cycle as key_load is ignored.
- key_bit_valid outside LOAD is ignored.
- Effective request:
  - i != LUT_CH: req_eff[i] = (req_q[i] ^ key[i] ^ KPOL[i]) & en[i].
  - i == LUT_CH: req_eff[i] = p[{req_q[i]^key[i]^KPOL[i], en[i]}], with p = key[NCH+3:NCH]. The correct LUT is 4'b1000 (AND).
- Pipeline: req is registered into req_q each cycle. Request at cycle t gives req_q at t+1 and irq_valid at t+2 (2-cycle latency).
- Arbitration: lowest-index set bit of req_eff wins.
- Handshake:
  - If irq_valid=0, or irq_valid&irq_ready, load irq_valid=|req_eff and irq_id=winner.
  - Otherwise hold irq_id and irq_valid stable, even if the request drops or a higher-priority request arrives.
- After an accept, the same channel may be regranted next cycle if still requesting (level semantics).
- No req_eff set: irq_valid=0 and irq_id holds its last value.
- Wrong key: the controller must still operate deterministically as a corrupted function. Grants may be spurious or missing; there is no error flag.
- rst during LOAD or mid-handshake: return to the reset state. The partial key is discarded.

Optional Feature:
- KEY_PARITY_EN defined:
  - KEY_W grows by 1; the final bit is even parity over the preceding key bits.
  - On a parity mismatch, return to LOCKED instead of ACTIVE, with key register cleared and key_loaded=0.
  - Adds output key_err (1 bit). It pulses for 1 cycle on mismatch and is 0 at reset.
- KEY_PARITY_EN undefined: no parity bit, no key_err port, and behaviour is exactly as above.

Decomposition:
- Package locked_irq_pkg holds:
  - state enum {LOCKED, LOAD, ACTIVE};
  - LUT_AND constant 4'b1000;
  - key-field offset localparams (XOR_LSB=0, LUT_LSB=NCH);
  - function prio_enc(vector) returning the lowest set index.
- One sub-module, key_shift_loader: owns the FSM, bit counter, key register, and the optional parity check. It outputs key[] and key_loaded.

Test Plan:
- Reset then load the correct key (KPOL with LUT 4'b1000, LSB first, 13 bits) -> key_loaded=1 the cycle after the 13th valid bit.
- Correct key, en=all 1s, req=9'b001001000 at t -> irq_valid=1, irq_id=3 at t+2; with irq_ready=1, regranted 3 while req held. Drop req[3] -> grant 6.
- Correct key, irq_ready=0 while irq_id=6 is pending, then raise req[0] -> irq_id stays 6. Pulse irq_ready -> next grant is 0.
- Wrong key (key bit 0 flipped), req=0, en[0]=1 -> spurious irq_valid=1, irq_id=0 at cycle 2.
- key_load pulse mid-grant -> irq_valid=0 and key_loaded=0 next cycle; no grants until the reload completes.
- KEY_PARITY_EN: load the correct key with a wrong parity bit -> key_err 1-cycle pulse, FSM LOCKED, key_loaded=0. Load with correct parity -> key_loaded=1.
